// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and defaults for the data-memory arbiter.
//   state_t      - arbiter FSM states (IDLE / ACCESS / DONE)
//   REQ_CPU/DMA  - requester IDs used as grant values
//   DMEM_ADDR_W  - default word-address width into dmem
//   DMEM_DATA_W  - default data width
package dmem_arbiter_pkg;

    localparam int unsigned DMEM_ADDR_W = 14;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester handshakes and the dmem bus.
//   Port 0 (CPU) : iReq0 iWe0 iAddr0 iWrData0 -> oAck0 oRdData0
//   Port 1 (DMA) : iReq1 iWe1 iAddr1 iWrData1 -> oAck1 oRdData1
//   dmem side    : oMemAddr oMemWrData oMemWr oMemRd <- iMemRdData
//   status       : oBusy
//   modport slave  - the arbiter's view
//   modport master - the requesters' / memory's view
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) ();

    logic              iReq0;
    logic              iWe0;
    logic [ADDR_W-1:0] iAddr0;
    logic [DATA_W-1:0] iWrData0;
    logic              oAck0;
    logic [DATA_W-1:0] oRdData0;

    logic              iReq1;
    logic              iWe1;
    logic [ADDR_W-1:0] iAddr1;
    logic [DATA_W-1:0] iWrData1;
    logic              oAck1;
    logic [DATA_W-1:0] oRdData1;

    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWrData;
    logic              oMemWr;
    logic              oMemRd;
    logic [DATA_W-1:0] iMemRdData;
    logic              oBusy;

    modport slave (
        input  iReq0, iWe0, iAddr0, iWrData0,
        input  iReq1, iWe1, iAddr1, iWrData1,
        input  iMemRdData,
        output oAck0, oRdData0, oAck1, oRdData1,
        output oMemAddr, oMemWrData, oMemWr, oMemRd, oBusy
    );

    modport master (
        output iReq0, iWe0, iAddr0, iWrData0,
        output iReq1, iWe1, iAddr1, iWrData1,
        output iMemRdData,
        input  oAck0, oRdData0, oAck1, oRdData1,
        input  oMemAddr, oMemWrData, oMemWr, oMemRd, oBusy
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req[1:0] - request lines (bit 0 = CPU, bit 1 = DMA)
//   pointer  - port favoured when both request
//   grant    - winning requester ID
//   anyReq   - at least one request present
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic       grant,
    output logic       anyReq
);

    always_comb begin
        anyReq = |req;
        grant  = REQ_CPU;
        case (req)
            2'b01:   grant = REQ_CPU;
            2'b10:   grant = REQ_DMA;
            2'b11:   grant = pointer;
            default: grant = REQ_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, level-sensitive dmem between the CPU
// load/store stage (port 0) and the DMA/debug loader (port 1).
//   iClk, iRst - clock, asynchronous active-high reset
//   bus        - dmem_arbiter_if.slave: both req/ack ports plus the dmem bus
// Each access runs IDLE -> ACCESS -> DONE; every output is a register, so the
// dmem address, data and strobes are glitch-free and stable for the whole
// ACCESS cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input logic           iClk,
    input logic           iRst,
    dmem_arbiter_if.slave bus
);

    state_t            state, stateNext;
    logic              pointer, pointerNext;
    logic              grantQ, weQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWrDataQ;
    logic [DATA_W-1:0] rdData0Q, rdData1Q;
    logic              memWrQ, memRdQ, ack0Q, ack1Q, busyQ;

    logic              arbGrant, anyReq, grantNow;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWrData;
    logic              ack0Next, ack1Next, capture0, capture1;

    rr_arb2 uArb (
        .req     ({bus.iReq1, bus.iReq0}),
        .pointer (pointer),
        .grant   (arbGrant),
        .anyReq  (anyReq)
    );

    always_comb begin
        selWe     = bus.iWe0;
        selAddr   = bus.iAddr0;
        selWrData = bus.iWrData0;
        if (arbGrant == REQ_DMA) begin
            selWe     = bus.iWe1;
            selAddr   = bus.iAddr1;
            selWrData = bus.iWrData1;
        end
    end

    always_comb begin
        stateNext   = state;
        pointerNext = pointer;
        grantNow    = 1'b0;
        ack0Next    = 1'b0;
        ack1Next    = 1'b0;
        capture0    = 1'b0;
        capture1    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (anyReq) begin
                    stateNext   = ST_ACCESS;
                    grantNow    = 1'b1;
                    pointerNext = ~arbGrant;
                end
            end
            ST_ACCESS: begin
                stateNext = ST_DONE;
                ack0Next  = (grantQ == REQ_CPU);
                ack1Next  = (grantQ == REQ_DMA);
                capture0  = !weQ && (grantQ == REQ_CPU);
                capture1  = !weQ && (grantQ == REQ_DMA);
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Strobes are computed from the grant decision so they are registered
    // into the ACCESS cycle itself and drop again on the edge leaving it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= ST_IDLE;
            pointer    <= REQ_CPU;
            grantQ     <= REQ_CPU;
            weQ        <= 1'b0;
            memAddrQ   <= '0;
            memWrDataQ <= '0;
            rdData0Q   <= '0;
            rdData1Q   <= '0;
            memWrQ     <= 1'b0;
            memRdQ     <= 1'b0;
            ack0Q      <= 1'b0;
            ack1Q      <= 1'b0;
            busyQ      <= 1'b0;
        end else begin
            state   <= stateNext;
            pointer <= pointerNext;
            if (grantNow) begin
                grantQ     <= arbGrant;
                weQ        <= selWe;
                memAddrQ   <= selAddr;
                memWrDataQ <= selWrData;
            end
            if (capture0) rdData0Q <= bus.iMemRdData;
            if (capture1) rdData1Q <= bus.iMemRdData;
            memWrQ <= grantNow && selWe;
            memRdQ <= grantNow && !selWe;
            ack0Q  <= ack0Next;
            ack1Q  <= ack1Next;
            busyQ  <= (stateNext != ST_IDLE);
        end
    end

    assign bus.oMemAddr   = memAddrQ;
    assign bus.oMemWrData = memWrDataQ;
    assign bus.oMemWr     = memWrQ;
    assign bus.oMemRd     = memRdQ;
    assign bus.oAck0      = ack0Q;
    assign bus.oAck1      = ack1Q;
    assign bus.oRdData0   = rdData0Q;
    assign bus.oRdData1   = rdData1Q;
    assign bus.oBusy      = busyQ;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory (dmem) between two requesters: port 0 = CPU load/store stage, port 1 = DMA/debug loader.
- dmem is level-sensitive and combinational on read. This block therefore guarantees the following:
  - Address and write data are stable for a whole access cycle.
  - The read and write strobes are never asserted together.
  - Strobes are low whenever no access is in progress.
- Requesters use a req/ack handshake. Arbitration between them is round-robin.

Parameters:
ADDR_W, 14, word-address width into dmem (16K entries)
DATA_W, 32, data width

Ports:
iClk  input  1  clock; all state updates on rising edge
iRst  input  1  asynchronous, active-high reset
iReq0  input  1  port 0 request; held high until oAck0
iWe0  input  1  port 0: 1=write, 0=read; stable while iReq0
iAddr0  input  ADDR_W  port 0 address; stable while iReq0
iWrData0  input  DATA_W  port 0 write data; stable while iReq0
oAck0  output  1  one-cycle completion pulse to port 0
oRdData0  output  DATA_W  port 0 read data; valid when oAck0=1
iReq1, iWe1, iAddr1, iWrData1, oAck1, oRdData1  same widths and meanings as port 0, for port 1
oMemAddr  output  ADDR_W  to dmem iAddr
oMemWrData  output  DATA_W  to dmem iWrData
oMemWr  output  1  to dmem iMemWr
oMemRd  output  1  to dmem iMemRd
iMemRdData  input  DATA_W  from dmem oRdData
oBusy  output  1  high in ACCESS and DONE

Behaviour:
- Reset:
  - Clock and reset are fixed: single clock iClk; iRst is asynchronous and active-high.
  - iRst forces state=IDLE and priority pointer=0.
  - All outputs go to 0: oMemWr, oMemRd, oAck0/1, oBusy, oMemAddr, oMemWrData, oRdData0/1.
  - An access in flight when reset asserts is abandoned. No ack is issued for it.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If any iReqN=1 at the clock edge, the arbiter grants one port and moves to ACCESS.
  - On the grant it latches that port's addr, wdata, we and the grant ID.
  - If no iReqN=1, it stays in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the port equal to the pointer wins.
  - After any grant, the pointer moves to the other port.
  - Result: worst-case wait for a continuously requesting port is one foreign access (3 cycles).
- ACCESS (exactly 1 cycle):
  - oMemAddr and oMemWrData show the latched values.
  - Strobes: oMemRd=!we, oMemWr=we. Exactly one strobe is high.
  - On the exiting edge, iMemRdData is captured into oRdDataN of the granted port (reads only).
  - Then move to DONE.
- DONE (1 cycle):
  - oAckN=1 for the granted port only. Strobes are 0.
  - oRdDataN stays valid and is held until that port's next read completes.
  - Next state is IDLE.
- Latency: request sampled at edge E, ACCESS in cycle E+1, oAck in cycle E+2. Peak throughput is one access per 3 cycles.
- Requester rule: deassert iReqN the cycle after oAckN. If iReqN is still high in the IDLE cycle after DONE, it is treated as a new request.
- In IDLE, oMemAddr and oMemWrData hold their last values.
- iReq changes during ACCESS or DONE are ignored; the latched values are used.
- Writes leave oRdDataN unchanged.
- Address wrap is not applicable: full-width addresses pass straight through, with no arithmetic.

Decomposition:
- Shared package/include holds:
  - state encoding constants (ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2)
  - requester IDs (REQ_CPU=1'b0, REQ_DMA=1'b1)
  - the global ADDR_W/DATA_W defaults.
- One sub-module is natural: rr_arb2.
  - Inputs: req[1:0], pointer. Outputs: grant ID, any_req. Purely combinational.
  - The pointer register stays in dmem_arbiter.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: port 0 write to 0x0010, assert iRst during cycle E+1.
  - Required: oMemWr drops immediately; oAck0 never pulses; state=IDLE; pointer=0.
- Single write then read:
  - Stimulus: port 0 writes 0xDEADBEEF to 0x0123, then reads 0x0123.
  - Required: oMemWr=1 in exactly one cycle; each oAck0 arrives 2 cycles after req sampled; oRdData0=0xDEADBEEF.
- Simultaneous requests from reset:
  - Stimulus: port 0 reads 0x0004, port 1 writes 0x55AA55AA to 0x0008, both asserted in the same cycle.
  - Required: port 0 granted first (oAck0 at E+2); oAck1 at E+5; port 1 data written.
- Fairness:
  - Stimulus: both ports hold iReq continuously for 8 accesses.
  - Required: grants alternate 0,1,0,1…; the gap between consecutive acks of one port is always 6 cycles.
- Strobe exclusivity and idle:
  - Checks throughout random traffic: assert that oMemWr&oMemRd==0 on every cycle, and that both strobes are 0 in IDLE and DONE.
- Read data hold:
  - Stimulus: port 1 reads 0x0100 = 0x0000CAFE, then port 0 writes 0x0100 = 0x12345678.
  - Required: oRdData1 stays 0x0000CAFE; oRdData0 is unchanged by the write.
